// File: rtl/id_stage_fwd_if.sv
// ID-stage bus bundle: IF/ID inputs, EX/MEM and MEM/WB forwarding inputs,
// hazard/branch outputs and the ID/EX latch outputs.
interface id_stage_fwd_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned RW = $clog2(NREGS);

    logic            if_valid;
    logic [31:0]     if_insn;
    logic [XLEN-1:0] if_pc;
    logic            ex_ready;
    logic            exmem_wr_en;
    logic            exmem_is_load;
    logic [RW-1:0]   exmem_rd;
    logic [XLEN-1:0] exmem_value;
    logic            memwb_wr_en;
    logic [RW-1:0]   memwb_rd;
    logic [XLEN-1:0] memwb_value;

    logic            id_stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            idex_valid;
    logic [31:0]     idex_ir;
    logic [XLEN-1:0] idex_pc;
    logic [XLEN-1:0] idex_a;
    logic [XLEN-1:0] idex_b;
    logic [XLEN-1:0] idex_imm;

    // Pipeline / environment side
    modport master (
        output if_valid, if_insn, if_pc, ex_ready,
        output exmem_wr_en, exmem_is_load, exmem_rd, exmem_value,
        output memwb_wr_en, memwb_rd, memwb_value,
        input  id_stall, branch_taken, branch_target,
        input  idex_valid, idex_ir, idex_pc, idex_a, idex_b, idex_imm
    );

    // ID stage side
    modport slave (
        input  if_valid, if_insn, if_pc, ex_ready,
        input  exmem_wr_en, exmem_is_load, exmem_rd, exmem_value,
        input  memwb_wr_en, memwb_rd, memwb_value,
        output id_stall, branch_taken, branch_target,
        output idex_valid, idex_ir, idex_pc, idex_a, idex_b, idex_imm
    );
endinterface

// File: rtl/id_stage_fwd.sv
// MIPS ID stage: register file, EX/MEM + MEM/WB forwarding, load-use and
// branch hazard detection, BEQ/BNE resolution in ID, and the ID/EX latch.
module id_stage_fwd #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0020,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_BNE   = 6'h05,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_ADDI  = 6'h08
) (
    input logic           clk,
    input logic           rst_n,
    id_stage_fwd_if.slave bus
);
    localparam int unsigned RW = $clog2(NREGS);

    logic [XLEN-1:0] rf_q [NREGS];

    logic            idex_valid_q;
    logic [31:0]     idex_ir_q;
    logic [XLEN-1:0] idex_pc_q, idex_a_q, idex_b_q, idex_imm_q;

    logic [5:0]      id_op;
    logic [RW-1:0]   id_rs, id_rt;
    logic            rt_used, is_branch;
    logic [RW-1:0]   ex_rt, ex_dest;
    logic            load_use, br_hz, hz;
    logic [XLEN-1:0] opnd_a, opnd_b, imm_sext;

    // Destination register of an instruction; 0 means "writes nothing".
    function automatic logic [RW-1:0] wr_dest(input logic [31:0] insn);
        logic [RW-1:0] dest;
        dest = '0;
        if (insn[31:26] == 6'h00) begin
            dest = insn[11 +: RW];
        end else if (insn[31:26] == OP_LW || insn[31:26] == OP_ADDI) begin
            dest = insn[16 +: RW];
        end
        return dest;
    endfunction

    // Decode and hazard detection
    always_comb begin
        id_op     = bus.if_insn[31:26];
        id_rs     = bus.if_insn[21 +: RW];
        id_rt     = bus.if_insn[16 +: RW];
        rt_used   = (id_op == 6'h00) || (id_op == OP_BEQ) || (id_op == OP_BNE) ||
                    (id_op == OP_SW);
        is_branch = (id_op == OP_BEQ) || (id_op == OP_BNE);
        ex_rt     = idex_ir_q[16 +: RW];
        ex_dest   = wr_dest(idex_ir_q);
        load_use  = idex_valid_q && (idex_ir_q[31:26] == OP_LW) && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (rt_used && ex_rt == id_rt));
        // Branches compare in ID, so any producer still in EX, or a load in MEM, must drain.
        br_hz     = is_branch &&
                    ((idex_valid_q && ex_dest != '0 &&
                      (ex_dest == id_rs || ex_dest == id_rt)) ||
                     (bus.exmem_wr_en && bus.exmem_is_load && bus.exmem_rd != '0 &&
                      (bus.exmem_rd == id_rs || bus.exmem_rd == id_rt)));
        hz        = bus.if_valid && (load_use || br_hz);
    end

    // Operand select: r0, then EX/MEM (non-load), then MEM/WB write-through, then regfile
    always_comb begin
        if (id_rs == '0) begin
            opnd_a = '0;
        end else if (bus.exmem_wr_en && bus.exmem_rd == id_rs && !bus.exmem_is_load) begin
            opnd_a = bus.exmem_value;
        end else if (bus.memwb_wr_en && bus.memwb_rd == id_rs) begin
            opnd_a = bus.memwb_value;
        end else begin
            opnd_a = rf_q[id_rs];
        end

        if (id_rt == '0) begin
            opnd_b = '0;
        end else if (bus.exmem_wr_en && bus.exmem_rd == id_rt && !bus.exmem_is_load) begin
            opnd_b = bus.exmem_value;
        end else if (bus.memwb_wr_en && bus.memwb_rd == id_rt) begin
            opnd_b = bus.memwb_value;
        end else begin
            opnd_b = rf_q[id_rt];
        end

        imm_sext = {{(XLEN-16){bus.if_insn[15]}}, bus.if_insn[15:0]};
    end

    // Stall, branch resolution and target; outputs held low during reset
    always_comb begin
        bus.id_stall      = rst_n & (hz | ~bus.ex_ready);
        bus.branch_taken  = rst_n & bus.if_valid & ~(hz | ~bus.ex_ready) &
                            (((id_op == OP_BEQ) & (opnd_a == opnd_b)) |
                             ((id_op == OP_BNE) & (opnd_a != opnd_b)));
        bus.branch_target = bus.if_pc + XLEN'(4) + (imm_sext << 2);
    end

    // Register file; r0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.memwb_wr_en && bus.memwb_rd != '0) begin
            rf_q[bus.memwb_rd] <= bus.memwb_value;
        end
    end

    // ID/EX latch: hold on !ex_ready, bubble on hazard or empty IF/ID, else issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_q <= 1'b0;
            idex_ir_q    <= NOP_INSN;
            idex_pc_q    <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
        end else if (!bus.ex_ready) begin
            idex_valid_q <= idex_valid_q;
        end else if (hz || !bus.if_valid) begin
            idex_valid_q <= 1'b0;
            idex_ir_q    <= NOP_INSN;
            idex_pc_q    <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
        end else begin
            idex_valid_q <= 1'b1;
            idex_ir_q    <= bus.if_insn;
            idex_pc_q    <= bus.if_pc;
            idex_a_q     <= opnd_a;
            idex_b_q     <= opnd_b;
            idex_imm_q   <= imm_sext;
        end
    end

    // ID/EX outputs
    always_comb begin
        bus.idex_valid = idex_valid_q;
        bus.idex_ir    = idex_ir_q;
        bus.idex_pc    = idex_pc_q;
        bus.idex_a     = idex_a_q;
        bus.idex_b     = idex_b_q;
        bus.idex_imm   = idex_imm_q;
    end
endmodule

// File: tb/tb_id_stage_fwd.sv
// Self-checking bench for id_stage_fwd: expected ID/EX contents are queued
// when an instruction is presented and compared after the capturing edge.
module tb_id_stage_fwd;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam logic [31:0] NOP   = 32'h0000_0020;

    typedef struct packed {
        logic        v;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } idex_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    idex_t exp_q [$];
    idex_t last_exp;
    idex_t bubble;
    int    checks = 0;
    int    failures = 0;

    id_stage_fwd_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    id_stage_fwd #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_add(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                           input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic idex_t mk(input logic [31:0] insn, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
        idex_t e;
        e.v   = 1'b1;
        e.ir  = insn;
        e.pc  = pc;
        e.a   = a;
        e.b   = b;
        e.imm = {{16{insn[15]}}, insn[15:0]};
        return e;
    endfunction

    // Push expectation, clock once, pop and compare against the latch.
    task automatic cycle(input string tag, input idex_t e);
        idex_t got_exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        check_eq({tag, ".valid"}, {31'd0, bus.idex_valid}, {31'd0, got_exp.v});
        check_eq({tag, ".ir"}, bus.idex_ir, got_exp.ir);
        check_eq({tag, ".pc"}, bus.idex_pc, got_exp.pc);
        check_eq({tag, ".a"}, bus.idex_a, got_exp.a);
        check_eq({tag, ".b"}, bus.idex_b, got_exp.b);
        check_eq({tag, ".imm"}, bus.idex_imm, got_exp.imm);
        last_exp = got_exp;
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] insn, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_insn  = insn;
        bus.if_pc    = pc;
        #1;
    endtask

    task automatic rf_write(input int rd, input logic [31:0] val);
        bus.if_valid    = 1'b0;
        bus.memwb_wr_en = 1'b1;
        bus.memwb_rd    = 5'(rd);
        bus.memwb_value = val;
        cycle("rfwr", bubble);
        bus.memwb_wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] insn;
        bubble = '{v: 1'b0, ir: NOP, default: '0};

        bus.if_valid      = 1'b0;
        bus.if_insn       = NOP;
        bus.if_pc         = '0;
        bus.ex_ready      = 1'b1;
        bus.exmem_wr_en   = 1'b0;
        bus.exmem_is_load = 1'b0;
        bus.exmem_rd      = '0;
        bus.exmem_value   = '0;
        bus.memwb_wr_en   = 1'b0;
        bus.memwb_rd      = '0;
        bus.memwb_value   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst.valid", {31'd0, bus.idex_valid}, 32'd0);
        check_eq("rst.ir", bus.idex_ir, NOP);
        check_eq("rst.a", bus.idex_a, 32'd0);
        check_eq("rst.stall", {31'd0, bus.id_stall}, 32'd0);
        check_eq("rst.taken", {31'd0, bus.branch_taken}, 32'd0);
        rst_n = 1'b1;

        rf_write(3, 32'd7);
        rf_write(1, 32'd5);
        rf_write(2, 32'd5);

        // Plain regfile read
        present(r_add(5, 3, 3), 32'h40);
        check_eq("add.stall", {31'd0, bus.id_stall}, 32'd0);
        cycle("add", mk(r_add(5, 3, 3), 32'h40, 32'd7, 32'd7));

        // EX/MEM beats MEM/WB (MEM/WB also writes r3=4 this cycle)
        bus.exmem_wr_en = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_value = 32'd9;
        bus.memwb_wr_en = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_value = 32'd4;
        present(r_add(6, 3, 0), 32'h44);
        cycle("fwd_exmem", mk(r_add(6, 3, 0), 32'h44, 32'd9, 32'd0));

        // MEM/WB write-through
        bus.exmem_wr_en = 1'b0;
        bus.memwb_rd = 5'd7; bus.memwb_value = 32'd11;
        present(r_add(8, 7, 0), 32'h48);
        cycle("fwd_memwb", mk(r_add(8, 7, 0), 32'h48, 32'd11, 32'd0));

        // r0 ignores forwarding; r3 now 4 from the earlier write
        bus.memwb_rd = 5'd0; bus.memwb_value = 32'hdead_beef;
        present(r_add(9, 0, 3), 32'h4c);
        cycle("r0_read", mk(r_add(9, 0, 3), 32'h4c, 32'd0, 32'd4));
        bus.memwb_wr_en = 1'b0;

        // Load-use: lw r2,0(r1) then add r4,r2,r1
        insn = i_type(6'h23, 1, 2, 16'h0000);
        present(insn, 32'h50);
        cycle("lw", mk(insn, 32'h50, 32'd5, 32'd5));
        present(r_add(4, 2, 1), 32'h54);
        check_eq("lu.stall", {31'd0, bus.id_stall}, 32'd1);
        cycle("lu.bubble", bubble);
        check_eq("lu.release", {31'd0, bus.id_stall}, 32'd0);
        cycle("lu.issue", mk(r_add(4, 2, 1), 32'h54, 32'd5, 32'd5));

        // beq r1,r2,-1 at 0x100: taken, target 0x100; bne not taken
        insn = i_type(6'h04, 1, 2, 16'hffff);
        present(insn, 32'h100);
        check_eq("beq.taken", {31'd0, bus.branch_taken}, 32'd1);
        check_eq("beq.target", bus.branch_target, 32'h100);
        cycle("beq", mk(insn, 32'h100, 32'd5, 32'd5));
        insn = i_type(6'h05, 1, 2, 16'hffff);
        present(insn, 32'h100);
        check_eq("bne.taken", {31'd0, bus.branch_taken}, 32'd0);
        cycle("bne", mk(insn, 32'h100, 32'd5, 32'd5));

        // Branch hazard on a writing ID/EX instruction (addi r1)
        insn = i_type(6'h08, 0, 1, 16'h0003);
        present(insn, 32'h104);
        cycle("addi", mk(insn, 32'h104, 32'd0, 32'd5));
        insn = i_type(6'h04, 1, 2, 16'h0000);
        present(insn, 32'h108);
        check_eq("bhz.stall", {31'd0, bus.id_stall}, 32'd1);
        check_eq("bhz.taken", {31'd0, bus.branch_taken}, 32'd0);
        cycle("bhz.bubble", bubble);
        check_eq("bhz.taken2", {31'd0, bus.branch_taken}, 32'd1);
        check_eq("bhz.target", bus.branch_target, 32'h10c);
        cycle("bhz.issue", mk(insn, 32'h108, 32'd5, 32'd5));

        // Branch hazard on a load in EX/MEM
        bus.exmem_wr_en = 1'b1; bus.exmem_is_load = 1'b1; bus.exmem_rd = 5'd2;
        insn = i_type(6'h04, 3, 2, 16'h0000);
        present(insn, 32'h200);
        check_eq("bld.stall", {31'd0, bus.id_stall}, 32'd1);
        cycle("bld.bubble", bubble);
        bus.exmem_wr_en = 1'b0; bus.exmem_is_load = 1'b0;

        // Target wrap at top and bottom of the address space
        bus.if_valid = 1'b0;
        bus.if_insn = i_type(6'h04, 0, 0, 16'h0001);
        bus.if_pc = 32'hffff_fff8;
        #1;
        check_eq("wrap.top", bus.branch_target, 32'h0);
        check_eq("wrap.novalid", {31'd0, bus.branch_taken}, 32'd0);
        bus.if_insn = i_type(6'h04, 0, 0, 16'hfffe);
        bus.if_pc = 32'h0;
        #1;
        check_eq("wrap.bot", bus.branch_target, 32'hffff_fffc);
        cycle("wrap.bubble", bubble);

        // ex_ready low for 3 cycles: latch holds
        present(r_add(5, 3, 3), 32'h300);
        cycle("pre_hold", mk(r_add(5, 3, 3), 32'h300, 32'd4, 32'd4));
        bus.ex_ready = 1'b0;
        insn = i_type(6'h04, 0, 0, 16'h0000);
        present(insn, 32'h304);
        for (int i = 0; i < 3; i++) begin
            check_eq("hold.stall", {31'd0, bus.id_stall}, 32'd1);
            check_eq("hold.taken", {31'd0, bus.branch_taken}, 32'd0);
            cycle("hold", last_exp);
        end
        bus.ex_ready = 1'b1;
        #1;
        check_eq("unhold.taken", {31'd0, bus.branch_taken}, 32'd1);
        cycle("unhold", mk(insn, 32'h304, 32'd0, 32'd0));

        // Mid-stream asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst.valid", {31'd0, bus.idex_valid}, 32'd0);
        check_eq("mrst.ir", bus.idex_ir, NOP);
        check_eq("mrst.taken", {31'd0, bus.branch_taken}, 32'd0);
        check_eq("mrst.stall", {31'd0, bus.id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        present(r_add(9, 3, 3), 32'h400);
        cycle("post_rst", mk(r_add(9, 3, 3), 32'h400, 32'd0, 32'd0));

        if (exp_q.size() != 0) begin
            check_eq("sb.empty", 32'(exp_q.size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
